// File: rtl/prog_state_machine.sv
// prog_state_machine: table-driven state machine with per-state input-match and dwell-timeout transitions.
// Define PROG_FSM_TIMEOUT_EN to enable the timeout path; otherwise only input matches move the state.
module prog_state_machine #(
    parameter int STATE_W = 2,
    parameter int IN_W = 2,
    parameter int TMO_W = 8,
    localparam int CFG_W = 2 * IN_W + 2 * STATE_W + TMO_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sync_rst,
    input  logic [IN_W-1:0]    in_vec,
    input  logic               cfg_we,
    input  logic [STATE_W-1:0] cfg_addr,
    input  logic [CFG_W-1:0]   cfg_wdata,
    output logic [STATE_W-1:0] state_out,
    output logic [TMO_W-1:0]   dwell_cnt,
    output logic               trans_p,
    output logic               tmo_p
);
    localparam int NS = 1 << STATE_W;

    logic [CFG_W-1:0]   tbl [NS];
    logic [CFG_W-1:0]   ent;
    logic [IN_W-1:0]    mask, match;
    logic [STATE_W-1:0] nxt, tmo_next, state_d;
    logic [TMO_W-1:0]   tmo_limit, dwell_d;
    logic               hit, tmo, trans_d, tmo_d;

    always_comb begin
        ent       = tbl[state_out];
        mask      = ent[IN_W-1:0];
        match     = ent[2*IN_W-1:IN_W];
        nxt       = ent[2*IN_W +: STATE_W];
        tmo_limit = ent[2*IN_W+STATE_W +: TMO_W];
        tmo_next  = ent[2*IN_W+STATE_W+TMO_W +: STATE_W];
        hit       = (|mask) && ((in_vec & mask) == (match & mask));
`ifdef PROG_FSM_TIMEOUT_EN
        tmo       = (|tmo_limit) && (dwell_cnt == tmo_limit);
`else
        tmo       = 1'b0;
`endif
        state_d   = sync_rst ? '0 : hit ? nxt : tmo ? tmo_next : state_out;
        trans_d   = !sync_rst && (hit || tmo);
        tmo_d     = !sync_rst && !hit && tmo;
        dwell_d   = (sync_rst || hit || tmo) ? '0 :
                    (&dwell_cnt) ? dwell_cnt : dwell_cnt + TMO_W'(1);
    end

`ifndef PROG_FSM_TIMEOUT_EN
    // Timeout fields are still stored so the table word layout is build-independent.
    logic unused_tmo;
    assign unused_tmo = ^{tmo_limit, tmo_next};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_out <= '0;
            dwell_cnt <= '0;
            trans_p   <= 1'b0;
            tmo_p     <= 1'b0;
            for (int i = 0; i < NS; i++) tbl[i] <= '0;
        end else begin
            state_out <= state_d;
            dwell_cnt <= dwell_d;
            trans_p   <= trans_d;
            tmo_p     <= tmo_d;
            if (cfg_we) tbl[cfg_addr] <= cfg_wdata;
        end
    end
endmodule

// File: tb/tb_prog_state_machine.sv
// tb_prog_state_machine: directed checks of table transitions, timeout, priorities, config timing and saturation.
module tb_prog_state_machine;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sync_rst = 1'b0;
    logic [1:0]  in_vec = 2'b00;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'b00;
    logic [15:0] cfg_wdata = 16'h0000;
    logic [1:0]  state_out;
    logic [7:0]  dwell_cnt;
    logic        trans_p, tmo_p;
    int          checks = 0;
    int          failures = 0;
    logic        any_trans;

    prog_state_machine dut (
        .clk(clk), .reset(reset), .sync_rst(sync_rst), .in_vec(in_vec),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .state_out(state_out), .dwell_cnt(dwell_cnt), .trans_p(trans_p), .tmo_p(tmo_p)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] s, input logic [7:0] d,
                           input logic t, input logic o);
        chk({tag, "_state"}, 32'(state_out), 32'(s));
        chk({tag, "_dwell"}, 32'(dwell_cnt), 32'(d));
        chk({tag, "_trans"}, 32'(trans_p), 32'(t));
        chk({tag, "_tmo"}, 32'(tmo_p), 32'(o));
    endtask

    initial begin
        #2;
        chk_all("por", 2'd0, 8'd0, 1'b0, 1'b0);
        reset = 1'b1;
        // write entry 0: mask=01 match=01 next=1
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'h0015; in_vec = 2'b10;
        tick();
        cfg_we = 1'b0;
        chk_all("wr0", 2'd0, 8'd1, 1'b0, 1'b0);
        tick();
        chk_all("nomatch", 2'd0, 8'd2, 1'b0, 1'b0);
        in_vec = 2'b01;
        tick();
        chk_all("match", 2'd1, 8'd0, 1'b1, 1'b0);
        in_vec = 2'b00;
        tick();
        chk_all("hold1", 2'd1, 8'd1, 1'b0, 1'b0);
        // sync_rst together with writing entry 1: mask=0 limit=3 tmo_next=2
        sync_rst = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'h80C0;
        tick();
        sync_rst = 1'b0; cfg_we = 1'b0;
        chk_all("srst", 2'd0, 8'd0, 1'b0, 1'b0);
        in_vec = 2'b01;
        tick();
        in_vec = 2'b00;
        chk_all("enter1", 2'd1, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("dwell_seq", 32'(dwell_cnt), 32'(i));
            chk("dwell_state", 32'(state_out), 32'd1);
        end
        tick();
`ifdef PROG_FSM_TIMEOUT_EN
        chk_all("timeout", 2'd2, 8'd0, 1'b1, 1'b1);
        tick();
        chk_all("post_tmo", 2'd2, 8'd1, 1'b0, 1'b0);
        repeat (4) tick();
        chk_all("pre_areset", 2'd2, 8'd5, 1'b0, 1'b0);
`else
        chk_all("no_timeout", 2'd1, 8'd4, 1'b0, 1'b0);
        tick();
        chk_all("post_tmo", 2'd1, 8'd5, 1'b0, 1'b0);
        repeat (4) tick();
        chk_all("pre_areset", 2'd1, 8'd9, 1'b0, 1'b0);
`endif
        #2 reset = 1'b0;
        #1;
        chk_all("areset", 2'd0, 8'd0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        in_vec = 2'b01;
        tick();
        chk("inert01_state", 32'(state_out), 32'd0);
        chk("inert01_trans", 32'(trans_p), 32'd0);
        in_vec = 2'b10;
        tick();
        chk("inert10_state", 32'(state_out), 32'd0);
        in_vec = 2'b11;
        tick();
        chk("inert11_state", 32'(state_out), 32'd0);
        chk("inert11_trans", 32'(trans_p), 32'd0);
        // entry 0 back to 0015; entry 1: mask=01 match=01 next=3 limit=3 tmo_next=2
        in_vec = 2'b00;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'h0015;
        tick();
        cfg_addr = 2'd1; cfg_wdata = 16'h80F5;
        tick();
        cfg_we = 1'b0; in_vec = 2'b01;
        tick();
        chk_all("enter1b", 2'd1, 8'd0, 1'b1, 1'b0);
        in_vec = 2'b00;
        repeat (3) tick();
        chk_all("dwell3", 2'd1, 8'd3, 1'b0, 1'b0);
        in_vec = 2'b01;
        tick();
        chk_all("match_over_tmo", 2'd3, 8'd0, 1'b1, 1'b0);
        sync_rst = 1'b1;
        tick();
        chk_all("srst_from3", 2'd0, 8'd0, 1'b0, 1'b0);
        tick();
        chk_all("srst_vs_match", 2'd0, 8'd0, 1'b0, 1'b0);
        sync_rst = 1'b0;
        // clear entry 0 on the same edge it matches
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'h0000;
        tick();
        cfg_we = 1'b0;
        chk_all("old_entry", 2'd1, 8'd0, 1'b1, 1'b0);
        in_vec = 2'b00; sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0; in_vec = 2'b01;
        tick();
        chk_all("new_entry", 2'd0, 8'd1, 1'b0, 1'b0);
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        chk("sat_start", 32'(dwell_cnt), 32'd0);
        any_trans = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            tick();
            any_trans = any_trans | trans_p;
            if (n == 254) chk("sat_254", 32'(dwell_cnt), 32'd254);
            if (n == 255) chk("sat_255", 32'(dwell_cnt), 32'd255);
        end
        chk("sat_300", 32'(dwell_cnt), 32'd255);
        chk("sat_state", 32'(state_out), 32'd0);
        chk("sat_trans", 32'(any_trans), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
